// File: rtl/id_remap_if.sv
// Allocation / release / response bundle for the ID remap allocator.
interface id_remap_if #(
  parameter int ID_WIDTH = 4,
  parameter int UID_W    = 4
);
  logic                alloc_valid;
  logic [ID_WIDTH-1:0] alloc_id;
  logic                alloc_ready;
  logic [UID_W-1:0]    alloc_uid;
  logic                free_valid;
  logic [UID_W-1:0]    free_uid;
  logic                free_ready;
  logic                rsp_valid;
  logic [ID_WIDTH-1:0] rsp_id;

  modport master (
    output alloc_valid, alloc_id,
    output free_valid, free_uid,
    input  alloc_ready, alloc_uid,
    input  free_ready, rsp_valid, rsp_id
  );

  modport slave (
    input  alloc_valid, alloc_id,
    input  free_valid, free_uid,
    output alloc_ready, alloc_uid,
    output free_ready, rsp_valid, rsp_id
  );
endinterface

// File: rtl/id_remap_allocator.sv
// Remaps AXI IDs onto {row,col} unique IDs; one row per bound original ID.
// Optional ID_REMAP_ERR_CHECK_EN: sticky err flag on illegal frees.
module id_remap_allocator #(
  parameter int ID_WIDTH = 4,
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 4,
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
  localparam int UID_W = ROW_W + COL_W,
  localparam int CNT_W = $clog2(NUM_ROWS * NUM_COLS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  id_remap_if.slave        bus,
  output logic             full,
  output logic [CNT_W-1:0] outstanding,
  output logic             err
);

  logic [NUM_ROWS-1:0]                               bound_q, bound_d;
  logic [NUM_ROWS-1:0][ID_WIDTH-1:0]                 bid_q, bid_d;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                 bmap_q, bmap_d;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][ID_WIDTH-1:0]   sid_q, sid_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_WIDTH-1:0] rsp_id_q, rsp_id_d;
  logic                full_q, full_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                hit, unb, col_ok, accept, legal;
  logic [ROW_W-1:0]    hit_row, unb_row, tgt_row, fr_row;
  logic [COL_W-1:0]    tgt_col, fr_col;
  logic [NUM_COLS-1:0] hit_map, unb_map, tgt_map;
  logic [ID_WIDTH-1:0] fr_id;

  // Descending loops so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    unb     = 1'b0;
    hit_row = '0;
    unb_row = '0;
    hit_map = '0;
    unb_map = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (bound_q[r] && bid_q[r] == bus.alloc_id) begin
        hit     = 1'b1;
        hit_row = ROW_W'(r);
        hit_map = bmap_q[r];
      end
      if (!bound_q[r]) begin
        unb     = 1'b1;
        unb_row = ROW_W'(r);
        unb_map = bmap_q[r];
      end
    end
    tgt_row = hit ? hit_row : unb_row;
    tgt_map = hit ? hit_map : unb_map;
    col_ok  = 1'b0;
    tgt_col = '0;
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (!tgt_map[c]) begin
        col_ok  = 1'b1;
        tgt_col = COL_W'(c);
      end
    end
  end

  assign bus.alloc_ready = (hit | unb) & col_ok;
  assign accept          = bus.alloc_valid & bus.alloc_ready;
  assign bus.alloc_uid   = accept ? {tgt_row, tgt_col} : '0;
  assign bus.free_ready  = 1'b1;

  assign fr_row = bus.free_uid[UID_W-1:COL_W];
  assign fr_col = bus.free_uid[COL_W-1:0];

  // Out-of-range indices never match any row/col, so they read as illegal.
  always_comb begin
    legal = 1'b0;
    fr_id = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (fr_row == ROW_W'(r) && fr_col == COL_W'(c) && bmap_q[r][c]) begin
          legal = bus.free_valid;
          fr_id = sid_q[r][c];
        end
      end
    end
  end

  always_comb begin
    bound_d = bound_q;
    bid_d   = bid_q;
    bmap_d  = bmap_q;
    sid_d   = sid_q;
    if (legal) begin
      bmap_d[fr_row][fr_col] = 1'b0;
      if (bmap_d[fr_row] == '0 && !(accept && tgt_row == fr_row))
        bound_d[fr_row] = 1'b0;
    end
    if (accept) begin
      bmap_d[tgt_row][tgt_col] = 1'b1;
      sid_d[tgt_row][tgt_col]  = bus.alloc_id;
      bound_d[tgt_row]         = 1'b1;
      bid_d[tgt_row]           = bus.alloc_id;
    end
    cnt_d       = cnt_q + CNT_W'(accept) - CNT_W'(legal);
    full_d      = (&bound_d) & (&bmap_d);
    rsp_valid_d = legal;
    rsp_id_d    = legal ? fr_id : rsp_id_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bound_q     <= '0;
      bid_q       <= '0;
      bmap_q      <= '0;
      sid_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      full_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      bound_q     <= bound_d;
      bid_q       <= bid_d;
      bmap_q      <= bmap_d;
      sid_q       <= sid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      full_q      <= full_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign full          = full_q;
  assign outstanding   = cnt_q;

`ifdef ID_REMAP_ERR_CHECK_EN
  logic err_q, err_d;
  assign err_d = err_q | (bus.free_valid & ~legal);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_id_remap_allocator.sv
// Randomized scoreboard bench for id_remap_allocator (4 rows x 4 cols).
// Reference model: a uid->id map; a row is bound exactly while it holds a slot.
module tb_id_remap_allocator;
  localparam int R = 4;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       full;
  logic [4:0] outstanding;
  logic       err;

  id_remap_if #(.ID_WIDTH(4), .UID_W(4)) bus ();

  id_remap_allocator dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .full        (full),
    .outstanding (outstanding),
    .err         (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int occ[int];
  bit m_err    = 1'b0;
  bit exp_rdy[$];
  int exp_uid[$];
  int rq[$];
  int n_free   = 0;
  int n_rsp    = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit row_busy(int r);
    for (int c = 0; c < C; c++)
      if (occ.exists(r * C + c)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int row_owner(int r);
    for (int c = 0; c < C; c++)
      if (occ.exists(r * C + c)) return occ[r * C + c];
    return -1;
  endfunction

  function automatic void m_alloc(int id, output bit ok, output int uid);
    int tgt = -1;
    ok  = 1'b0;
    uid = 0;
    for (int r = 0; r < R && tgt < 0; r++)
      if (row_busy(r) && row_owner(r) == id) tgt = r;
    if (tgt < 0)
      for (int r = 0; r < R && tgt < 0; r++)
        if (!row_busy(r)) tgt = r;
    if (tgt < 0) return;
    for (int c = 0; c < C; c++)
      if (!occ.exists(tgt * C + c)) begin
        ok  = 1'b1;
        uid = tgt * C + c;
        return;
      end
  endfunction

  task automatic cycle(bit av, int aid, bit fv, int fuid);
    bit ok;
    int uid;
    @(posedge clk);
    #1;
    check("outstanding", int'(outstanding), occ.num());
    check("full", int'(full), int'(occ.num() == R * C));
    check("err", int'(err), int'(m_err));
    bus.alloc_valid = av;
    bus.alloc_id    = 4'(aid);
    bus.free_valid  = fv;
    bus.free_uid    = 4'(fuid);
    m_alloc(aid, ok, uid);
    if (av) begin
      exp_rdy.push_back(ok);
      exp_uid.push_back(ok ? uid : 0);
    end
    if (fv && occ.exists(fuid)) begin
      rq.push_back(occ[fuid]);
      occ.delete(fuid);
      n_free++;
    end else if (fv) begin
`ifdef ID_REMAP_ERR_CHECK_EN
      m_err = 1'b1;
`endif
    end
    if (av && ok) occ[uid] = aid;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 0);
  endtask

  // Asynchronous reset landing mid-cycle, away from either clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_outstanding", int'(outstanding), 0);
    check("rst_full", int'(full), 0);
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_err", int'(err), 0);
    bus.alloc_valid = 1'b0;
    bus.free_valid  = 1'b0;
    occ.delete();
    rq.delete();
    exp_rdy.delete();
    exp_uid.delete();
    m_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.alloc_valid) begin
        if (exp_rdy.size() == 0) begin
          check("alloc_unexpected", 1, 0);
        end else begin
          check("alloc_ready", int'(bus.alloc_ready), int'(exp_rdy.pop_front()));
          check("alloc_uid", int'(bus.alloc_uid), exp_uid.pop_front());
        end
      end
      if (bus.rsp_valid) begin
        n_rsp++;
        if (rq.size() == 0) check("rsp_spurious", 1, 0);
        else check("rsp_id", int'(bus.rsp_id), rq.pop_front());
      end
    end
  end

  initial begin
    int keys[$];
    int fu;
    bus.alloc_valid = 1'b0;
    bus.alloc_id    = '0;
    bus.free_valid  = 1'b0;
    bus.free_uid    = '0;
    repeat (2) @(negedge clk);
    check("init_outstanding", int'(outstanding), 0);
    check("init_full", int'(full), 0);
    check("init_rsp_valid", int'(bus.rsp_valid), 0);
    check("init_rsp_id", int'(bus.rsp_id), 0);
    check("init_err", int'(err), 0);
    check("init_alloc_ready", int'(bus.alloc_ready), 1);
    check("free_ready", int'(bus.free_ready), 1);
    rst = 1'b1;

    // Same ID fills its row, fifth request stalls.
    for (int i = 0; i < 5; i++) cycle(1'b1, 5, 1'b0, 0);
    idle(1);
    check("row0_count", int'(outstanding), 4);
    do_reset();

    // One row per ID, then fill to full.
    for (int i = 1; i <= 4; i++) cycle(1'b1, i, 1'b0, 0);
    cycle(1'b1, 7, 1'b0, 0);
    idle(1);
    check("not_full_yet", int'(full), 0);
    for (int k = 0; k < 3; k++)
      for (int i = 1; i <= 4; i++) cycle(1'b1, i, 1'b0, 0);
    idle(1);
    check("full_set", int'(full), 1);
    do_reset();

    // Free then reuse lowest column.
    cycle(1'b1, 9, 1'b0, 0);
    cycle(1'b1, 9, 1'b0, 0);
    cycle(1'b0, 0, 1'b1, 0);
    idle(1);
    cycle(1'b1, 9, 1'b0, 0);
    idle(2);
    do_reset();

    // Same-cycle free and alloc into the same row keeps it bound.
    cycle(1'b1, 10, 1'b0, 0);
    cycle(1'b1, 10, 1'b1, 0);
    idle(1);
    cycle(1'b1, 11, 1'b0, 0);
    idle(2);
    do_reset();

    // Illegal free.
    cycle(1'b0, 0, 1'b1, 3);
    idle(3);
    do_reset();

    // Reset with six slots outstanding.
    for (int i = 0; i < 6; i++) cycle(1'b1, i % 2, 1'b0, 0);
    idle(1);
    do_reset();
    cycle(1'b1, 6, 1'b0, 0);
    idle(3);

    for (int n = 0; n < 3000; n++) begin
      bit av;
      bit fv;
      av = ($urandom_range(0, 9) < 6);
      fv = ($urandom_range(0, 9) < 4);
      keys.delete();
      foreach (occ[k]) keys.push_back(k);
      if (keys.size() > 0 && $urandom_range(0, 9) < 8)
        fu = keys[$urandom_range(0, keys.size() - 1)];
      else
        fu = $urandom_range(0, 15);
      cycle(av, $urandom_range(0, 5), fv, fu);
    end
    idle(3);
    check("rsp_count", n_rsp, n_free);
    check("rsp_pending", rq.size(), 0);
    check("alloc_pending", exp_rdy.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
